// File: rtl/din_debounce_pkg.sv
// din_debounce_pkg: types and constants shared by the din_debounce block and its bench.
//   deb_state_e           - debouncer state, 2-bit encoding
//   GLITCH_MAX            - saturation value of the aborted-qualification counter
//   DEFAULT_SYNC_STAGES   - default synchroniser depth, shared with the D-FF stage bench
//   DEFAULT_STABLE_CYCLES - default qualification length, shared with the D-FF stage bench
//   idle_state()          - stable state that corresponds to a given settled level
package din_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        QUAL_HI   = 2'b01,
        STABLE_HI = 2'b10,
        QUAL_LO   = 2'b11
    } deb_state_e;

    localparam int GLITCH_MAX            = 255;
    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 50000;

    function automatic deb_state_e idle_state(input logic level);
        return level ? STABLE_HI : STABLE_LO;
    endfunction

endpackage

// File: rtl/din_debounce_bit_sync.sv
// bit_sync: multi-flop synchroniser for one asynchronous bit.
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset; every stage loads RESET_VAL
//   din    - asynchronous input bit
//   s      - synchronised output (last stage)
// Kept generic so other asynchronous inputs can reuse it.
module bit_sync #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s
);

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] stage_in;

    // Stage 0 is the only flop that sees the raw input; each later stage
    // takes its predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_in[gi] = din;
            end else begin : g_chain
                assign stage_in[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {STAGES{RESET_VAL}};
        end else begin
            sync_reg <= stage_in;
        end
    end

    assign s = sync_reg[STAGES-1];

endmodule

// File: rtl/din_debounce.sv
// din_debounce: synchronise and debounce a raw button/switch input.
//   clk        - single clock, posedge
//   rst_n      - asynchronous active-low reset
//   din        - raw asynchronous input
//   enable     - 1 = qualify level changes, 0 = freeze dout
//   glitch_clr - synchronous clear of glitch_cnt (wins over an increment)
//   dout       - debounced level (feeds the downstream D flip-flop)
//   rise_pulse - one-cycle pulse when dout goes 0->1
//   fall_pulse - one-cycle pulse when dout goes 1->0
//   busy       - high while a level change is being qualified
//   glitch_cnt - saturating count of aborted qualifications
module din_debounce
    import din_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = 16,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       enable,
    input  logic       glitch_clr,
    output logic       dout,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("din_debounce: SYNC_STAGES must be in 2..4");
        end
        if (STABLE_CYCLES < 2) begin : g_bad_stable
            $error("din_debounce: STABLE_CYCLES must be at least 2");
        end
        if ((64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad_cnt_w
            $error("din_debounce: CNT_W too small for STABLE_CYCLES");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       G_MAX    = 8'(GLITCH_MAX);

    logic s;

    bit_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .s     (s)
    );

    deb_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dout_reg, dout_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic             busy_reg, busy_next;
    logic [7:0]       glitch_reg, glitch_next;
    logic             glitch_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= idle_state(RESET_LEVEL);
            cnt_reg    <= '0;
            dout_reg   <= RESET_LEVEL;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            glitch_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            dout_reg   <= dout_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
            busy_reg   <= busy_next;
            glitch_reg <= glitch_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dout_next  = dout_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        glitch_inc = 1'b0;

        case (state_reg)
            STABLE_LO: begin
                if (enable && s) begin
                    state_next = QUAL_HI;
                    cnt_next   = CNT_ONE;
                end
            end
            QUAL_HI: begin
                // Dropping enable is a deliberate abort, not a bounce.
                if (!enable) begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end else if (!s) begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                    dout_next  = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (enable && !s) begin
                    state_next = QUAL_LO;
                    cnt_next   = CNT_ONE;
                end
            end
            QUAL_LO: begin
                if (!enable) begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                end else if (s) begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                    dout_next  = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = idle_state(dout_reg);
                cnt_next   = '0;
            end
        endcase

        // busy is registered alongside the state, so derive it from the next state.
        busy_next = (state_next == QUAL_HI) || (state_next == QUAL_LO);

        if (glitch_clr) begin
            glitch_next = '0;
        end else if (glitch_inc && glitch_reg != G_MAX) begin
            glitch_next = glitch_reg + 8'd1;
        end else begin
            glitch_next = glitch_reg;
        end
    end

    assign dout       = dout_reg;
    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;
    assign busy       = busy_reg;
    assign glitch_cnt = glitch_reg;

endmodule

// File: tb/tb_din_debounce.sv
module tb_din_debounce;
    import din_debounce_pkg::*;

    localparam int SYNC   = DEFAULT_SYNC_STAGES;
    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       enable = 1'b1;
    logic       glitch_clr = 1'b0;
    logic       dout;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       busy;
    logic [7:0] glitch_cnt;

    din_debounce #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (16),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .enable     (enable),
        .glitch_clr (glitch_clr),
        .dout       (dout),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    string phase = "reset";

    // Reference model: a value pushed into the delay line reaches the
    // qualifier SYNC edges later; m_run is the length of the current run
    // of enabled samples that disagree with the accepted level.
    logic m_q[$];
    logic m_dout;
    logic m_rise;
    logic m_fall;
    int   m_run;
    int   m_glitch;

    task automatic model_reset();
        m_q = {};
        for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
        m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        m_run = 0; m_glitch = 0;
    endtask

    task automatic model_edge(input logic d, input logic en, input logic clr);
        logic sv;
        bit   aborted;
        sv = m_q.pop_front();
        m_q.push_back(d);
        aborted = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!en) begin
            m_run = 0;
        end else if (sv != m_dout) begin
            m_run++;
            if (m_run == STABLE) begin
                m_dout = sv;
                if (sv) m_rise = 1'b1; else m_fall = 1'b1;
                m_run = 0;
            end
        end else if (m_run > 0) begin
            aborted = 1'b1;
            m_run = 0;
        end
        if (clr) m_glitch = 0;
        else if (aborted && m_glitch < 255) m_glitch++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dout", {7'd0, dout}, {7'd0, m_dout});
        chk("rise_pulse", {7'd0, rise_pulse}, {7'd0, m_rise});
        chk("fall_pulse", {7'd0, fall_pulse}, {7'd0, m_fall});
        chk("busy", {7'd0, busy}, {7'd0, (m_run > 0)});
        chk("glitch_cnt", glitch_cnt, 8'(m_glitch));
    endtask

    // Drive inputs just after an edge, let the next edge sample them, check 1 time unit later.
    task automatic step(input logic d, input logic en, input logic clr);
        din = d; enable = en; glitch_clr = clr;
        @(posedge clk);
        if (rst_n) model_edge(d, en, clr);
        #1;
        check_all();
    endtask

    initial begin
        int rise_at;
        int busy_at;
        int fall_at;
        int len;
        logic lvl;
        logic en_r;

        model_reset();
        // Reset state
        repeat (2) @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        phase = "idle";
        repeat (20) step(1'b0, 1'b1, 1'b0);

        // Clean rising step: busy after SYNC+1 edges, dout after SYNC+STABLE edges.
        phase = "rise";
        rise_at = -1; busy_at = -1;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (busy === 1'b1 && busy_at < 0) busy_at = k;
            if (rise_pulse === 1'b1 && rise_at < 0) rise_at = k;
        end
        chk("busy_edge", 8'(busy_at), 8'(SYNC + 1));
        chk("rise_edge", 8'(rise_at), 8'(SYNC + STABLE));

        phase = "fall";
        fall_at = -1;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b1, 1'b0);
            if (fall_pulse === 1'b1 && fall_at < 0) fall_at = k;
        end
        chk("fall_edge", 8'(fall_at), 8'(SYNC + STABLE));

        // Five short pulses (STABLE-1 samples) are all rejected.
        phase = "glitch5";
        for (int g = 0; g < 5; g++) begin
            repeat (STABLE - 1) step(1'b1, 1'b1, 1'b0);
            repeat (4) step(1'b0, 1'b1, 1'b0);
        end
        chk("glitch_cnt5", glitch_cnt, 8'd5);
        chk("dout_after5", {7'd0, dout}, 8'd0);

        // Sixth abort lands on the same edge as glitch_clr.
        phase = "glitch_clr";
        repeat (STABLE - 1) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("glitch_cnt_clr", glitch_cnt, 8'd0);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        phase = "rise2";
        repeat (10) step(1'b1, 1'b1, 1'b0);
        phase = "fall2";
        repeat (10) step(1'b0, 1'b1, 1'b0);

        phase = "frozen";
        for (int k = 0; k < 10; k++) begin
            step(k[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
            chk("dout_frozen", {7'd0, dout}, 8'd0);
        end
        phase = "reenable";
        repeat (10) step(1'b1, 1'b1, 1'b0);

        // Back to low, then reset in the middle of a rising qualification.
        phase = "pre_rst";
        repeat (10) step(1'b0, 1'b1, 1'b0);
        repeat (SYNC + 2) step(1'b1, 1'b1, 1'b0);
        chk("busy_mid_qual", {7'd0, busy}, 8'd1);
        phase = "async_rst";
        #3;
        rst_n = 1'b0;
        din = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) step(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        phase = "post_rst";
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("no_rise_post_rst", {7'd0, rise_pulse}, 8'd0);
        end

        // 300 random short pulses: counter must saturate.
        phase = "saturate";
        for (int g = 0; g < 300; g++) begin
            repeat ($urandom_range(STABLE - 1, 1)) step(1'b1, 1'b1, 1'b0);
            repeat ($urandom_range(5, 2)) step(1'b0, 1'b1, 1'b0);
        end
        chk("glitch_sat", glitch_cnt, 8'd255);
        repeat (STABLE - 1) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        chk("glitch_sat_hold", glitch_cnt, 8'd255);

        // Random runs of din with occasional enable drops and clears.
        phase = "random";
        lvl = 1'b0;
        for (int r = 0; r < 250; r++) begin
            lvl = ~lvl;
            len = $urandom_range(8, 1);
            for (int k = 0; k < len; k++) begin
                en_r = ($urandom_range(9, 0) != 0);
                step(lvl, en_r, ($urandom_range(49, 0) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
